// File: rtl/fifo_wr_arbiter_pkg.sv
// Shared types and default configuration for the FIFO write-port arbiter.
package fifo_arb_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } arb_state_e;

    localparam int FIFO_WIDTH_DEF = 32;
    localparam int FIFO_DEPTH_DEF = 32;
    localparam int NUM_REQ_DEF    = 4;
    localparam int MAX_BURST_DEF  = 4;

    localparam int REQ_IDX_W = $clog2(NUM_REQ_DEF);
    localparam int CRED_W    = $clog2(FIFO_DEPTH_DEF + 1);

endpackage

// File: rtl/fifo_wr_arbiter_if.sv
// Producer-request, FIFO-write and FIFO-read-observe signals of the write-port arbiter.
interface fifo_wr_arbiter_if
    import fifo_arb_pkg::*;
#(
    parameter int FIFO_WIDTH = FIFO_WIDTH_DEF,
    parameter int NUM_REQ    = NUM_REQ_DEF,
    parameter int CW         = CRED_W
) ();

    logic [NUM_REQ-1:0]            req;
    logic [NUM_REQ*FIFO_WIDTH-1:0] req_data;
    logic [NUM_REQ-1:0]            gnt;
    logic                          full;
    logic                          empty;
    logic                          rd_en;
    logic                          wr_en;
    logic [FIFO_WIDTH-1:0]         data_in;
    logic [CW-1:0]                 credits;

    modport master (
        input  req, req_data, full, empty, rd_en,
        output gnt, wr_en, data_in, credits
    );

    modport slave (
        output req, req_data, full, empty, rd_en,
        input  gnt, wr_en, data_in, credits
    );

endinterface

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// Purpose: first set bit of mask searching upward from start, wrapping at N.
// Latency: purely combinational.
// Backpressure: none; vld=0 when the mask is empty.
module rr_pick
    import fifo_arb_pkg::*;
#(
    parameter int N  = NUM_REQ_DEF,
    parameter int IW = REQ_IDX_W
) (
    input  logic [N-1:0]  mask,
    input  logic [IW-1:0] start,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] idx,
    output logic          vld
);

    int            k;
    logic [IW-1:0] kk;

    always_comb begin
        gnt = '0;
        idx = '0;
        vld = 1'b0;
        k   = 0;
        kk  = '0;
        for (int i = 0; i < N; i++) begin
            k = int'(start) + i;
            if (k >= N) k = k - N;
            kk = IW'(k);
            if (!vld && mask[kk]) begin
                vld     = 1'b1;
                gnt[kk] = 1'b1;
                idx     = kk;
            end
        end
    end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Purpose: round-robin, burst-bounded sharing of one FIFO write port with credit tracking.
// Latency: gnt combinational in cycle t; wr_en/data_in registered in cycle t+1.
// Backpressure: gnt held at zero while credits==FIFO_DEPTH or full is set.
module fifo_wr_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int FIFO_WIDTH = FIFO_WIDTH_DEF,
    parameter int FIFO_DEPTH = FIFO_DEPTH_DEF,
    parameter int NUM_REQ    = NUM_REQ_DEF,
    parameter int MAX_BURST  = MAX_BURST_DEF
) (
    input  logic               clk,
    input  logic               rst,
    fifo_wr_arbiter_if.master  bus
);

    localparam int IW = $clog2(NUM_REQ);
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam int BW = $clog2(MAX_BURST + 1);

    arb_state_e          state, state_nxt;
    logic [IW-1:0]       owner, owner_nxt, rr_ptr, rr_nxt;
    logic [IW-1:0]       owner_inc, pick_inc, pick_start, pick_idx, gnt_idx;
    logic [BW-1:0]       burst_cnt, cnt_nxt;
    logic [NUM_REQ-1:0]  pick_mask, pick_gnt, owner_bit;
    logic                pick_vld, gnt_vld, keep_owner, can_grant;
    logic                grant_fire, read_fire;
    logic [CW-1:0]       credits;
    logic                wr_en_q;
    logic [FIFO_WIDTH-1:0] data_q;

    assign owner_inc  = (owner == IW'(NUM_REQ - 1)) ? '0 : owner + IW'(1);
    assign pick_inc   = (pick_idx == IW'(NUM_REQ - 1)) ? '0 : pick_idx + IW'(1);
    assign owner_bit  = NUM_REQ'(1) << owner;
    assign can_grant  = (credits < CW'(FIFO_DEPTH)) && !bus.full;

    // From IDLE the search starts at the rr pointer; mid-burst it skips the owner.
    assign pick_start = (state == IDLE) ? rr_ptr : owner_inc;
    assign pick_mask  = (state == IDLE) ? bus.req : (bus.req & ~owner_bit);

    rr_pick #(.N(NUM_REQ), .IW(IW)) u_pick (
        .mask  (pick_mask),
        .start (pick_start),
        .gnt   (pick_gnt),
        .idx   (pick_idx),
        .vld   (pick_vld)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            owner     <= '0;
            burst_cnt <= '0;
            rr_ptr    <= '0;
        end else begin
            state     <= state_nxt;
            owner     <= owner_nxt;
            burst_cnt <= cnt_nxt;
            rr_ptr    <= rr_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        owner_nxt  = owner;
        cnt_nxt    = burst_cnt;
        rr_nxt     = rr_ptr;
        gnt_vld    = 1'b0;
        keep_owner = 1'b0;
        gnt_idx    = owner;
        if (can_grant) begin
            case (state)
                IDLE: begin
                    if (pick_vld) begin
                        gnt_vld   = 1'b1;
                        gnt_idx   = pick_idx;
                        state_nxt = BURST;
                        owner_nxt = pick_idx;
                        cnt_nxt   = BW'(1);
                        rr_nxt    = pick_inc;
                    end
                end
                BURST: begin
                    // Owner keeps the port past MAX_BURST only when nobody else is waiting.
                    if (bus.req[owner] && ((burst_cnt < BW'(MAX_BURST)) || !pick_vld)) begin
                        gnt_vld    = 1'b1;
                        keep_owner = 1'b1;
                        if (burst_cnt < BW'(MAX_BURST)) cnt_nxt = burst_cnt + BW'(1);
                    end else if (pick_vld) begin
                        gnt_vld   = 1'b1;
                        gnt_idx   = pick_idx;
                        owner_nxt = pick_idx;
                        cnt_nxt   = BW'(1);
                        rr_nxt    = pick_inc;
                    end else begin
                        state_nxt = IDLE;
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_comb begin
        bus.gnt    = '0;
        grant_fire = gnt_vld && !rst;
        if (grant_fire) bus.gnt = keep_owner ? owner_bit : pick_gnt;
    end

    assign read_fire = bus.rd_en && !bus.empty && (credits != '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            credits <= '0;
            wr_en_q <= 1'b0;
            data_q  <= '0;
        end else begin
            case ({grant_fire, read_fire})
                2'b10:   credits <= credits + CW'(1);
                2'b01:   credits <= credits - CW'(1);
                default: credits <= credits;
            endcase
            wr_en_q <= grant_fire;
            if (grant_fire) data_q <= bus.req_data[gnt_idx*FIFO_WIDTH +: FIFO_WIDTH];
        end
    end

    assign bus.wr_en   = wr_en_q;
    assign bus.data_in = data_q;
    assign bus.credits = credits;

    a_credit_range: assert property (@(posedge clk) disable iff (rst) credits <= CW'(FIFO_DEPTH));
    a_gnt_onehot:   assert property (@(posedge clk) disable iff (rst) $onehot0(bus.gnt));

endmodule
